// File: rtl/trigger_event_capture.sv
// -----------------------------------------------------------------------------
// trigger_event_capture
//   Timestamps the trigger generator's A / C / fire pulses on rxclk, computes
//   the A->C and C->fire intervals, and queues one record per armed shot into a
//   first-word-fall-through FIFO. Also drives a stretched trig_out on fire.
//
// Ports
//   rxclk, rst                 clock, async active-high reset
//   arm                        shot enable; low forces IDLE and kills trig_out
//   detect_pls_0/1             generator pulses (A+fire / C), rising-edge used
//   pulse_tof                  ToF word captured with the record
//   timeout_cycles             max wait in WAIT_C / WAIT_FIRE (0 = no timeout)
//   stretch_len                trig_out width in cycles (0 acts as 1)
//   trig_out, busy             stretched fire pulse, registered busy flag
//   evt_valid/evt_rd           FIFO not-empty / pop strobe
//   evt_ts_a..evt_timeout      head record fields (0 when FIFO empty)
//   evt_count                  records held
//   overflow, ovf_clr          sticky dropped-push flag and its clear
// -----------------------------------------------------------------------------
module trigger_event_capture #(
   parameter int DEPTH_LOG2 = 3
) (
   input  logic                  rxclk,
   input  logic                  rst,
   input  logic                  arm,
   input  logic                  detect_pls_0,
   input  logic                  detect_pls_1,
   input  logic [31:0]           pulse_tof,
   input  logic [31:0]           timeout_cycles,
   input  logic [15:0]           stretch_len,
   output logic                  trig_out,
   output logic                  busy,
   output logic                  evt_valid,
   input  logic                  evt_rd,
   output logic [31:0]           evt_ts_a,
   output logic [31:0]           evt_dt_ac,
   output logic [31:0]           evt_dt_cf,
   output logic [31:0]           evt_tof,
   output logic                  evt_timeout,
   output logic [DEPTH_LOG2:0]   evt_count,
   output logic                  overflow,
   input  logic                  ovf_clr
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

   typedef struct packed {
      logic [31:0] ts_a;
      logic [31:0] dt_ac;
      logic [31:0] dt_cf;
      logic [31:0] tof;
      logic        timeout;
   } rec_t;

   typedef enum logic [2:0] {IDLE, WAIT_A, WAIT_C, WAIT_FIRE, DONE} state_t;

   state_t       state_q;
   logic         d0_q, d1_q;
   logic         edge0, edge1;
   logic [31:0]  ts_q, ts_a_q, ts_c_q, wait_q;
   logic [15:0]  str_q;
   logic         trig_q, busy_q;
   logic         tmo_hit, fire, tmo, push;
   rec_t         rec;

   assign edge0   = detect_pls_0 & ~d0_q;
   assign edge1   = detect_pls_1 & ~d1_q;
   assign tmo_hit = (timeout_cycles != 32'd0) && (wait_q == timeout_cycles);

   // Event beats timeout in the same cycle; a d0 edge in WAIT_C is not an event.
   always_comb begin
      fire = arm && (state_q == WAIT_FIRE) && edge0;
      tmo  = arm && tmo_hit &&
             (((state_q == WAIT_C) && !edge1) || ((state_q == WAIT_FIRE) && !edge0));
      push = fire | tmo;
      rec.ts_a    = ts_a_q;
      rec.dt_ac   = (state_q == WAIT_C) ? 32'hFFFF_FFFF : ts_c_q - ts_a_q;
      rec.dt_cf   = fire ? ts_q - ts_c_q : 32'hFFFF_FFFF;
      rec.tof     = pulse_tof;
      rec.timeout = tmo;
   end

   // Shot FSM, timestamp, wait counter and stretcher
   always_ff @(posedge rxclk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         d0_q    <= 1'b0;
         d1_q    <= 1'b0;
         ts_q    <= '0;
         ts_a_q  <= '0;
         ts_c_q  <= '0;
         wait_q  <= '0;
         str_q   <= '0;
         trig_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         d0_q   <= detect_pls_0;
         d1_q   <= detect_pls_1;
         busy_q <= (state_q == WAIT_C) || (state_q == WAIT_FIRE);
         if (!arm) begin
            state_q <= IDLE;
            ts_q    <= '0;
            wait_q  <= '0;
            str_q   <= '0;
            trig_q  <= 1'b0;
         end else begin
            // ts starts counting once the FSM has left IDLE, so the first
            // WAIT_A cycle reads 0
            if (state_q == IDLE)          ts_q <= '0;
            else if (ts_q != '1)          ts_q <= ts_q + 32'd1;

            if (fire) begin
               str_q  <= (stretch_len == 16'd0) ? 16'd1 : stretch_len;
               trig_q <= 1'b1;
            end else if (str_q != 16'd0) begin
               str_q  <= str_q - 16'd1;
               trig_q <= (str_q > 16'd1);
            end else begin
               trig_q <= 1'b0;
            end

            case (state_q)
               IDLE: state_q <= WAIT_A;
               WAIT_A: begin
                  if (edge0) begin
                     ts_a_q  <= ts_q;
                     wait_q  <= '0;
                     state_q <= WAIT_C;
                  end
               end
               WAIT_C: begin
                  if (edge1) begin
                     ts_c_q  <= ts_q;
                     wait_q  <= '0;
                     state_q <= WAIT_FIRE;
                  end else if (tmo) begin
                     state_q <= DONE;
                  end else if (wait_q != '1) begin
                     wait_q  <= wait_q + 32'd1;
                  end
               end
               WAIT_FIRE: begin
                  if (fire || tmo)          state_q <= DONE;
                  else if (wait_q != '1)    wait_q  <= wait_q + 32'd1;
               end
               DONE:    state_q <= DONE;
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign trig_out = trig_q;
   assign busy     = busy_q;

   // ---------------------------------------------------------------- FIFO
   rec_t                   mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0]  wp_q, rp_q;
   logic [DEPTH_LOG2:0]    cnt_q, cnt_d;
   logic                   ovf_q, ovf_d;
   logic                   full, pop, wr, drop;
   rec_t                   head;

   assign full = (cnt_q == FULL_CNT);
   assign pop  = evt_rd && (cnt_q != '0);
   // A pop in the same cycle frees the slot, so a full FIFO still accepts
   assign wr   = push && (!full || pop);
   assign drop = push && full && !pop;

   always_comb begin
      cnt_d = cnt_q;
      if (wr && !pop)      cnt_d = cnt_q + 1'b1;
      else if (!wr && pop) cnt_d = cnt_q - 1'b1;
      ovf_d = drop | (ovf_q & ~ovf_clr);
   end

   always_ff @(posedge rxclk or posedge rst) begin
      if (rst) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         if (wr)  wp_q <= wp_q + 1'b1;
         if (pop) rp_q <= rp_q + 1'b1;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   // Storage has no reset; the head is masked while empty instead
   always_ff @(posedge rxclk) begin
      if (wr) mem_q[wp_q] <= rec;
   end

   assign evt_valid   = (cnt_q != '0);
   assign head        = evt_valid ? mem_q[rp_q] : '0;
   assign evt_ts_a    = head.ts_a;
   assign evt_dt_ac   = head.dt_ac;
   assign evt_dt_cf   = head.dt_cf;
   assign evt_tof     = head.tof;
   assign evt_timeout = head.timeout;
   assign evt_count   = cnt_q;
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_trigger_event_capture.sv
module tb_trigger_event_capture;

   logic        rxclk = 1'b0;
   logic        rst = 1'b0;
   logic        arm = 1'b0;
   logic        detect_pls_0 = 1'b0;
   logic        detect_pls_1 = 1'b0;
   logic [31:0] pulse_tof = '0;
   logic [31:0] timeout_cycles = '0;
   logic [15:0] stretch_len = '0;
   logic        trig_out, busy, evt_valid, evt_timeout, overflow;
   logic        evt_rd = 1'b0;
   logic        ovf_clr = 1'b0;
   logic [31:0] evt_ts_a, evt_dt_ac, evt_dt_cf, evt_tof;
   logic [3:0]  evt_count;

   trigger_event_capture #(.DEPTH_LOG2(3)) dut (
      .rxclk(rxclk), .rst(rst), .arm(arm),
      .detect_pls_0(detect_pls_0), .detect_pls_1(detect_pls_1),
      .pulse_tof(pulse_tof), .timeout_cycles(timeout_cycles),
      .stretch_len(stretch_len), .trig_out(trig_out), .busy(busy),
      .evt_valid(evt_valid), .evt_rd(evt_rd), .evt_ts_a(evt_ts_a),
      .evt_dt_ac(evt_dt_ac), .evt_dt_cf(evt_dt_cf), .evt_tof(evt_tof),
      .evt_timeout(evt_timeout), .evt_count(evt_count),
      .overflow(overflow), .ovf_clr(ovf_clr)
   );

   always #4 rxclk = ~rxclk;

   typedef struct {
      logic [31:0] ts_a, dac, dcf, tof;
      logic        to;
   } rec_t;

   rec_t q[$];
   int   ntests = 0;
   int   nfail = 0;
   bit   exp_ovf = 0;
   bit   clr_on_push = 0;
   bit   pop_on_push = 0;

   task automatic tick();
      @(posedge rxclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, ".trig"}, 32'(trig_out), 32'd0);
      chk({tag, ".busy"}, 32'(busy), 32'd0);
      chk({tag, ".vld"},  32'(evt_valid), 32'd0);
      chk({tag, ".ovf"},  32'(overflow), 32'd0);
      chk({tag, ".cnt"},  32'(evt_count), 32'd0);
      chk({tag, ".tsa"},  evt_ts_a, 32'd0);
      chk({tag, ".dac"},  evt_dt_ac, 32'd0);
      chk({tag, ".dcf"},  evt_dt_cf, 32'd0);
      chk({tag, ".tof"},  evt_tof, 32'd0);
      chk({tag, ".to"},   32'(evt_timeout), 32'd0);
   endtask

   // One armed shot. Offsets are cycles after arm rises (rel 0); -1 = absent.
   // Model: ts reads rel-1 at cycle rel; waits are measured from state entry
   // (the cycle after the accepting edge); an event on the expiry cycle wins.
   task automatic run_shot(input int a, input int c, input int f, input int to,
                           input logic [31:0] tof, input int slen, input bit both,
                           input int x0, input int drop);
      int   cv, push_rel, smax, end_rel, r, lim, m;
      bit   fired;
      rec_t e;
      lim  = (drop < 0) ? 32'h7fff_ffff : drop;
      smax = (slen == 0) ? 1 : slen;
      push_rel = -1;
      fired = 1'b0;
      e.ts_a = a - 1;
      e.tof  = tof;
      e.to   = 1'b0;
      e.dac  = '1;
      e.dcf  = '1;
      cv = (c >= 0 && (to == 0 || c <= a + 1 + to)) ? c : -1;
      if (cv < 0) begin
         if (to != 0) begin
            push_rel = a + 1 + to;
            e.to = 1'b1;
         end
      end else if (f >= 0 && (to == 0 || f <= cv + 1 + to)) begin
         push_rel = f;
         fired = 1'b1;
         e.dac = cv - a;
         e.dcf = f - cv;
      end else if (to != 0) begin
         push_rel = cv + 1 + to;
         e.to = 1'b1;
         e.dac = cv - a;
      end
      if (push_rel >= lim) begin
         push_rel = -1;
         fired = 1'b0;
      end
      m = a;
      if (c > m) m = c;
      if (f > m) m = f;
      if (push_rel > m) m = push_rel;
      end_rel = (drop >= 0) ? drop + 3 : m + smax + 3;

      for (int rel = 0; rel < end_rel; rel++) begin
         arm            = (rel < lim);
         detect_pls_0   = (rel == a) || (rel == f) || (rel == x0);
         detect_pls_1   = (rel == c) || (both && rel == a);
         pulse_tof      = (push_rel >= 0 && rel > push_rel) ? ~tof : tof;
         ovf_clr        = clr_on_push && (rel == push_rel);
         evt_rd         = pop_on_push && (rel == push_rel);
         timeout_cycles = to;
         stretch_len    = 16'(slen);
         tick();
         r = rel + 1;
         chk("trig", 32'(trig_out), 32'(fired && r > f && r <= f + smax && r <= lim));
         if (r == a + 1) chk("busy_wa", 32'(busy), 32'd0);
         if (r == a + 2 && a < lim) chk("busy_wc", 32'(busy), 32'd1);
         if (push_rel >= 0 && r == push_rel) chk("cnt_pre", 32'(evt_count), 32'(q.size()));
         if (push_rel >= 0 && r == push_rel + 1) begin
            if (pop_on_push && q.size() > 0) void'(q.pop_front());
            if (q.size() < 8) q.push_back(e);
            else              exp_ovf = 1'b1;
            if (clr_on_push && q.size() < 8 && !exp_ovf) exp_ovf = 1'b0;
            chk("cnt_post", 32'(evt_count), 32'(q.size()));
            chk("vld_post", 32'(evt_valid), 32'd1);
            chk("ovf_post", 32'(overflow), 32'(exp_ovf));
         end
      end
      arm = 1'b0;
      detect_pls_0 = 1'b0;
      detect_pls_1 = 1'b0;
      evt_rd = 1'b0;
      ovf_clr = 1'b0;
      tick();
      tick();
      chk("end.busy", 32'(busy), 32'd0);
      chk("end.trig", 32'(trig_out), 32'd0);
      chk("end.ovf",  32'(overflow), 32'(exp_ovf));
      chk("end.cnt",  32'(evt_count), 32'(q.size()));
   endtask

   task automatic pop_check(input string tag);
      rec_t e;
      chk({tag, ".vld"}, 32'(evt_valid), 32'd1);
      if (q.size() == 0) begin
         ntests++;
         nfail++;
         $error("FAIL %s: observed record expected none", tag);
      end else begin
         e = q.pop_front();
         chk({tag, ".tsa"}, evt_ts_a, e.ts_a);
         chk({tag, ".dac"}, evt_dt_ac, e.dac);
         chk({tag, ".dcf"}, evt_dt_cf, e.dcf);
         chk({tag, ".tof"}, evt_tof, e.tof);
         chk({tag, ".to"},  32'(evt_timeout), 32'(e.to));
      end
      evt_rd = 1'b1;
      tick();
      evt_rd = 1'b0;
      chk({tag, ".cnt"}, 32'(evt_count), 32'(q.size()));
   endtask

   task automatic rand_shot(input bit allow_to);
      int a, c, f, to, k;
      a = int'($urandom_range(2, 15));
      c = a + int'($urandom_range(3, 40));
      f = c + int'($urandom_range(1, 40));
      to = 0;
      k = allow_to ? int'($urandom_range(0, 3)) : 0;
      if (k == 1) to = 200;
      if (k == 2) to = int'($urandom_range(1, 30));
      if (k == 3) begin
         c = -1;
         f = -1;
         to = int'($urandom_range(5, 20));
      end
      run_shot(a, c, f, to, $urandom, int'($urandom_range(0, 6)), 1'b0, a + 2, -1);
   endtask

   initial begin
      // Reset state
      #1 rst = 1'b1;
      #2 chk_zero_outputs("reset");
      tick();
      tick();
      rst = 1'b0;
      tick();

      // Directed full shot
      run_shot(100, 600, 5600, 0, 32'h1234_0042, 10, 1'b0, -1, -1);
      pop_check("shot1");
      chk("shot1.empty", 32'(evt_valid), 32'd0);

      // Timeout waiting for C
      run_shot(50, -1, -1, 1000, 32'hCAFE_0001, 4, 1'b0, -1, -1);
      pop_check("tmo");

      // A and C together in WAIT_A
      run_shot(20, 320, 820, 0, 32'h0BAD_F00D, 3, 1'b1, -1, -1);
      pop_check("both");

      // Nine shots, no reads
      for (int i = 0; i < 9; i++) rand_shot(1'b1);
      chk("nine.cnt", 32'(evt_count), 32'd8);
      chk("nine.ovf", 32'(overflow), 32'd1);

      // Full: clear collides with a dropped push, then push+pop together
      clr_on_push = 1'b1;
      rand_shot(1'b0);
      clr_on_push = 1'b0;
      pop_on_push = 1'b1;
      rand_shot(1'b0);
      pop_on_push = 1'b0;
      chk("full.cnt", 32'(evt_count), 32'd8);

      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      exp_ovf = 1'b0;
      chk("ovf_clr", 32'(overflow), 32'd0);

      for (int i = 0; i < 8; i++) pop_check("drain");
      chk("drain.vld", 32'(evt_valid), 32'd0);
      evt_rd = 1'b1;
      tick();
      evt_rd = 1'b0;
      chk("pop_empty.cnt", 32'(evt_count), 32'd0);

      // arm dropped in WAIT_FIRE, then during an active trig_out
      run_shot(10, 20, 40, 0, 32'h1111_2222, 5, 1'b0, -1, 30);
      chk("drop_wf.cnt", 32'(evt_count), 32'd0);
      run_shot(10, 20, 30, 0, 32'h3333_4444, 50, 1'b0, -1, 35);
      pop_check("drop_trig");

      // Async reset mid-shot with three records queued
      for (int i = 0; i < 3; i++) rand_shot(1'b0);
      for (int rel = 0; rel < 12; rel++) begin
         arm = 1'b1;
         detect_pls_0 = (rel == 5);
         detect_pls_1 = (rel == 10);
         timeout_cycles = '0;
         tick();
      end
      chk("pre_rst.busy", 32'(busy), 32'd1);
      chk("pre_rst.cnt",  32'(evt_count), 32'd3);
      #2 rst = 1'b1;
      #1 chk_zero_outputs("async_rst");
      arm = 1'b0;
      detect_pls_0 = 1'b0;
      detect_pls_1 = 1'b0;
      tick();
      rst = 1'b0;
      q.delete();
      exp_ovf = 1'b0;
      tick();
      chk("post_rst.cnt", 32'(evt_count), 32'd0);
      chk("post_rst.vld", 32'(evt_valid), 32'd0);

      run_shot(3, 8, 12, 0, 32'h5555_AAAA, 0, 1'b0, -1, -1);
      pop_check("post_rst");

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
